// File: rtl/fib_display_pkg.sv
// Seven-segment constants and hex glyph table shared by the display path,
// plus the Fibonacci value table used by the counter's o_fib flag.
package fib_display_pkg;
   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam int         DP_BIT  = 7;
   localparam int         FIB_N   = 24;

   localparam logic [FIB_N-1:0][15:0] FIB_TAB = {
      16'd46368, 16'd28657, 16'd17711, 16'd10946, 16'd6765, 16'd4181,
      16'd2584,  16'd1597,  16'd987,   16'd610,   16'd377,  16'd233,
      16'd144,   16'd89,    16'd55,    16'd34,    16'd21,   16'd13,
      16'd8,     16'd5,     16'd3,     16'd2,     16'd1,    16'd0};

   // Active-low g..a; "b" and "d" use the lowercase shapes.
   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction
endpackage

// File: rtl/fib_scan_display_if.sv
// Bundle between the counter core and the display scanner.
interface fib_scan_display_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 2
);
   logic [WIDTH-1:0]  count;
   logic [DIGITS-1:0] anodes;
   logic [7:0]        seven_seg;
   logic              display_on;

   modport master (output count, input anodes, seven_seg, display_on);
   modport slave  (input count, output anodes, seven_seg, display_on);
endinterface

// File: rtl/fib_scan_display_scan.sv
// Multiplexed digit scanner: dwells SCAN_DIV clocks per digit, anodes and
// segments registered together from the same digit index.
module fib_scan_display_scan
   import fib_display_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 2,
   parameter int SCAN_DIV = 100_000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   fib_scan_display_if.slave bus
);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SW-1:0]       scan_q, scan_d;
   logic [DW-1:0]       digit_q, digit_d;
   logic [DIGITS-1:0]   anodes_q;
   logic [7:0]          seg_q;
   logic                on_q;
   logic [DIGITS*4-1:0] cnt_pad;
   logic [3:0]          nibble;
   logic [6:0]          seg7;

   always_comb begin
      scan_d  = scan_q + 1'b1;
      digit_d = digit_q;
      if (scan_q == SW'(SCAN_DIV - 1)) begin
         scan_d  = '0;
         digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
      end
   end

   // Pad the count so the top digit reads zero-extended bits.
   always_comb begin
      cnt_pad             = '0;
      cnt_pad[WIDTH-1:0]  = bus.count;
      nibble              = cnt_pad[digit_q*4 +: 4];
   end

   hex_to_seven_seg u_hex (.i_hex(nibble), .o_seg(seg7));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         scan_q   <= '0;
         digit_q  <= '0;
         anodes_q <= '1;
         seg_q    <= SEG_OFF;
         on_q     <= 1'b0;
      end else begin
         scan_q   <= scan_d;
         digit_q  <= digit_d;
         anodes_q <= ~(DIGITS'(1) << digit_q);
         seg_q    <= {1'b1, seg7};
         on_q     <= 1'b1;
      end
   end

   assign bus.anodes     = anodes_q;
   assign bus.seven_seg  = seg_q;
   assign bus.display_on = on_q;
endmodule

// File: rtl/hex_to_seven_seg.sv
// One hex nibble to an active-low 7-segment pattern (g..a).
module hex_to_seven_seg
   import fib_display_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);
   assign o_seg = hex_seg(i_hex);
endmodule

// File: rtl/fib_scan_display.sv
// Prescaled up/down counter with load, wrap pulse and Fibonacci flag,
// shown on a scanned hex seven-segment display.
module fib_scan_display
   import fib_display_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 2,
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 100_000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_up_down,
   input  logic              i_load,
   input  logic [WIDTH-1:0]  i_load_value,
   output logic [WIDTH-1:0]  o_count,
   output logic              o_fib,
   output logic              o_wrap,
   output logic [DIGITS-1:0] o_anodes,
   output logic [7:0]        o_sevenSeg,
   output logic              o_display_on
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             tick;

   assign tick = i_enable && (presc_q == PW'(TICK_DIV - 1));

   // Load wins over a coincident tick and restarts the tick period.
   always_comb begin
      presc_d = presc_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      if (i_load) begin
         count_d = i_load_value;
         presc_d = '0;
      end else if (tick) begin
         presc_d = '0;
         if (i_up_down) begin
            count_d = count_q + 1'b1;
            wrap_d  = &count_q;
         end else begin
            count_d = count_q - 1'b1;
            wrap_d  = ~|count_q;
         end
      end else if (i_enable) begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         presc_q <= '0;
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      o_fib = 1'b0;
      for (int i = 0; i < FIB_N; i++)
         if ((32'(FIB_TAB[i]) < (32'd1 << WIDTH)) && (FIB_TAB[i] == 16'(count_q)))
            o_fib = 1'b1;
   end

   fib_scan_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) disp_if ();

   assign disp_if.count = count_q;

   fib_scan_display_scan #(
      .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
   ) u_scan (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (disp_if.slave)
   );

   assign o_count      = count_q;
   assign o_wrap       = wrap_q;
   assign o_anodes     = disp_if.anodes;
   assign o_sevenSeg   = disp_if.seven_seg;
   assign o_display_on = disp_if.display_on;
endmodule

// File: tb/tb_fib_scan_display.sv
// Directed bench for fib_scan_display at WIDTH=8, TICK_DIV=4, SCAN_DIV=2.
module tb_fib_scan_display;
   logic       clk = 1'b0;
   logic       rst, en, up, ld;
   logic [7:0] ld_val;
   logic       fib, wrap;
   int         checks = 0;
   int         errors = 0;

   fib_scan_display_if #(.WIDTH(8), .DIGITS(2)) mon ();

   fib_scan_display #(.WIDTH(8), .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2)) dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_up_down(up),
      .i_load(ld), .i_load_value(ld_val),
      .o_count(mon.count), .o_fib(fib), .o_wrap(wrap),
      .o_anodes(mon.anodes), .o_sevenSeg(mon.seven_seg),
      .o_display_on(mon.display_on));

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      ld = 1'b1; ld_val = v;
      step();
      ld = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; up = 1'b1; ld = 1'b1; ld_val = 8'h55;
      step(3);
      ld = 1'b0;
      checks += 6;
      if (mon.count !== 8'h00) begin errors++; $display("FAIL reset_count got %h exp 00", mon.count); end
      if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", wrap); end
      if (mon.display_on !== 1'b0) begin errors++; $display("FAIL reset_on got %b exp 0", mon.display_on); end
      if (mon.anodes !== 2'b11) begin errors++; $display("FAIL reset_anodes got %b exp 11", mon.anodes); end
      if (mon.seven_seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h exp FF", mon.seven_seg); end
      if (fib !== 1'b1) begin errors++; $display("FAIL reset_fib got %b exp 1", fib); end
   endtask

   task automatic test_count_up;
      logic [7:0] exp_c;
      logic       exp_f;
      rst = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         exp_c = 8'(k / 4);
         exp_f = (exp_c inside {8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8});
         checks += 3;
         if (mon.count !== exp_c) begin errors++; $display("FAIL up_count step %0d got %h exp %h", k, mon.count, exp_c); end
         if (fib !== exp_f) begin errors++; $display("FAIL up_fib count %h got %b exp %b", exp_c, fib, exp_f); end
         if (mon.display_on !== 1'b1) begin errors++; $display("FAIL up_on step %0d got %b exp 1", k, mon.display_on); end
      end
   endtask

   task automatic test_wrap;
      en = 1'b0;
      do_load(8'hFE);
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL load_nowrap got %b exp 0", wrap); end
      en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         checks++;
         if (wrap !== (k == 8)) begin errors++; $display("FAIL up_wrap step %0d got %b exp %b", k, wrap, (k == 8)); end
         if (k == 4) begin
            checks++;
            if (mon.count !== 8'hFF) begin errors++; $display("FAIL up_ff got %h exp FF", mon.count); end
         end
         if (k == 8) begin
            checks++;
            if (mon.count !== 8'h00) begin errors++; $display("FAIL up_00 got %h exp 00", mon.count); end
         end
      end
      up = 1'b0;
      do_load(8'h00);
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++;
         if (wrap !== (k == 4)) begin errors++; $display("FAIL dn_wrap step %0d got %b exp %b", k, wrap, (k == 4)); end
         if (k >= 4) begin
            checks++;
            if (mon.count !== 8'hFF) begin errors++; $display("FAIL dn_ff step %0d got %h exp FF", k, mon.count); end
         end
      end
   endtask

   task automatic test_load_priority;
      en = 1'b0; up = 1'b1;
      do_load(8'h30);
      en = 1'b1;
      step(3);
      do_load(8'h37);
      checks += 2;
      if (mon.count !== 8'h37) begin errors++; $display("FAIL ldtick_count got %h exp 37", mon.count); end
      if (wrap !== 1'b0) begin errors++; $display("FAIL ldtick_wrap got %b exp 0", wrap); end
      step(3);
      checks++;
      if (mon.count !== 8'h37) begin errors++; $display("FAIL ldtick_hold got %h exp 37", mon.count); end
      step();
      checks++;
      if (mon.count !== 8'h38) begin errors++; $display("FAIL ldtick_next got %h exp 38", mon.count); end
      // load over a tick that would have wrapped
      en = 1'b0;
      do_load(8'hFF);
      en = 1'b1;
      step(3);
      do_load(8'h00);
      checks += 2;
      if (mon.count !== 8'h00) begin errors++; $display("FAIL ldwrap_count got %h exp 00", mon.count); end
      if (wrap !== 1'b0) begin errors++; $display("FAIL ldwrap_wrap got %b exp 0", wrap); end
   endtask

   task automatic test_enable_hold;
      en = 1'b0; up = 1'b1;
      do_load(8'h10);
      en = 1'b1;
      step(2);
      en = 1'b0;
      step(5);
      checks++;
      if (mon.count !== 8'h10) begin errors++; $display("FAIL hold_count got %h exp 10", mon.count); end
      en = 1'b1;
      step();
      checks++;
      if (mon.count !== 8'h10) begin errors++; $display("FAIL hold_resume got %h exp 10", mon.count); end
      step();
      checks++;
      if (mon.count !== 8'h11) begin errors++; $display("FAIL hold_tick got %h exp 11", mon.count); end
   endtask

   task automatic test_scan;
      logic [1:0] an [10];
      logic [7:0] exp_s;
      en = 1'b0;
      do_load(8'hA5);
      step(3);
      for (int i = 0; i < 10; i++) begin
         an[i] = mon.anodes;
         exp_s = (mon.anodes == 2'b10) ? 8'h92 : (mon.anodes == 2'b01) ? 8'h88 : 8'hXX;
         checks++;
         if (mon.seven_seg !== exp_s) begin errors++; $display("FAIL scan_seg an %b got %h exp %h", mon.anodes, mon.seven_seg, exp_s); end
         step();
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (an[i+2] !== ~an[i]) begin errors++; $display("FAIL scan_dwell i %0d got %b exp %b", i, an[i+2], ~an[i]); end
      end
      checks++;
      if (mon.count !== 8'hA5) begin errors++; $display("FAIL scan_count got %h exp A5", mon.count); end
   endtask

   task automatic test_mid_reset;
      en = 1'b0; up = 1'b1;
      do_load(8'h20);
      en = 1'b1;
      step(4);
      checks++;
      if (mon.count !== 8'h21) begin errors++; $display("FAIL mr_pre got %h exp 21", mon.count); end
      step(2);
      rst = 1'b1;
      step();
      checks += 5;
      if (mon.count !== 8'h00) begin errors++; $display("FAIL mr_count got %h exp 00", mon.count); end
      if (mon.display_on !== 1'b0) begin errors++; $display("FAIL mr_on got %b exp 0", mon.display_on); end
      if (mon.anodes !== 2'b11) begin errors++; $display("FAIL mr_anodes got %b exp 11", mon.anodes); end
      if (mon.seven_seg !== 8'hFF) begin errors++; $display("FAIL mr_seg got %h exp FF", mon.seven_seg); end
      if (wrap !== 1'b0) begin errors++; $display("FAIL mr_wrap got %b exp 0", wrap); end
      rst = 1'b0;
      step();
      checks += 3;
      if (mon.display_on !== 1'b1) begin errors++; $display("FAIL rel_on got %b exp 1", mon.display_on); end
      if (mon.anodes !== 2'b10) begin errors++; $display("FAIL rel_anodes got %b exp 10", mon.anodes); end
      if (mon.seven_seg !== 8'hC0) begin errors++; $display("FAIL rel_seg got %h exp C0", mon.seven_seg); end
      step(2);
      checks++;
      if (mon.count !== 8'h00) begin errors++; $display("FAIL rel_notick got %h exp 00", mon.count); end
      step();
      checks++;
      if (mon.count !== 8'h01) begin errors++; $display("FAIL rel_tick got %h exp 01", mon.count); end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap();
      test_load_priority();
      test_enable_hold();
      test_scan();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
